mul_iter: RTL
=============

// Module: mul_iter
// PURPOSE
//  Multi-cycle iterative shift-add multiplier, the counterpart of the combinational divider in the
//  MDU: produces the full-width product HI:LO of two operands, signed or unsigned (MULT/MULTU).
//  Sits beside the divider in the EX-stage MDU; the pipeline stalls on busy and writes HI/LO on done.
//  Retires one multiplier bit per cycle, keeping the combinational path to one WIDTH-bit adder.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//  clk        in   1        single clock, rising edge
//  resetn     in   1        asynchronous, active-low reset
//  start      in   1        launch request; accepted only when busy==0
//  signed_op  in   1        1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with start
//  flush      in   1        abort in-flight operation (exception/branch flush)
//  a          in   WIDTH    multiplicand, sampled on accepted start
//  b          in   WIDTH    multiplier, sampled on accepted start
//  busy       out  1        high from cycle after accepted start until done cycle inclusive
//  done       out  1        one-cycle pulse; hi/lo valid from this cycle until next accepted start
//  hi         out  WIDTH    product[2*WIDTH-1:WIDTH]
//  lo         out  WIDTH    product[WIDTH-1:0]
// BEHAVIOUR
//  - Reset (resetn=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0; mid-operation reset
//    discards the operation with no done pulse.
//  - FSM: IDLE -> CALC on start&!flush; CALC -> FIN when counter reaches 0; FIN -> IDLE unconditionally;
//    any state -> IDLE on flush (flush wins over start in the same cycle).
//  - Accepted start (cycle T): latch mag_a=|a|, mag_b=|b| when signed_op else raw; neg=signed_op&(a[MSB]^b[MSB]);
//    acc (2*WIDTH+1 bits) = {0, mag_b}; counter=WIDTH.
//  - CALC, each cycle: if acc[0] then acc[upper WIDTH+1] += mag_a; then acc >>= 1 (logical); counter--.
//    |a| of most-negative value (0x8000_0000) is taken as unsigned 2^(WIDTH-1), no overflow.
//  - FIN: product = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0] (2*WIDTH-bit two's complement);
//    hi/lo registered from product, done=1 this cycle.
//  - Latency: start at T -> done high at T+WIDTH+1 (33 cycles for WIDTH=32); busy high T+1..T+WIDTH+1.
//  - start while busy: ignored, no effect on operands or count. start in the done cycle: ignored;
//    earliest re-launch is the cycle after done.
//  - flush in CALC/FIN: next cycle IDLE, busy=0, done stays 0, hi/lo keep previous result.
//  - hi/lo change only in FIN; held stable otherwise (reads between operations see last product).
//  - Operand zero still takes full WIDTH cycles (fixed latency, no early-out).
// STRUCTURE
//  - Shared package mdu_pkg: WIDTH default constant, FSM state encoding (IDLE/CALC/FIN),
//    MDU op codes (MULT, MULTU, DIV, DIVU) shared with the divider wrapper.
//  - One sub-module: mdu_abs (WIDTH-bit conditional two's-complement negate, en + value -> result),
//    instantiated for |a|, |b| and final 2*WIDTH-bit sign fix (parameterised width); reused by the
//    signed divider wrapper.
//  - Counter width $clog2(WIDTH+1); datapath one WIDTH+1-bit adder plus shifter.
// TESTING
//  1. unsigned a=0xFFFF_FFFF, b=0xFFFF_FFFF -> done at T+33, hi=0xFFFF_FFFE, lo=0x0000_0001.
//  2. signed a=0x8000_0000, b=0x8000_0000 -> hi=0x4000_0000, lo=0x0000_0000; signed a=-3, b=7 ->
//     hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
//  3. signed a=0xFFFF_FFFF(-1), b=0 -> hi=0, lo=0, still 33-cycle latency; busy high exactly 33 cycles.
//  4. after test 1 result, start a=5,b=6, flush at T+10 -> no done, busy low at T+11,
//     hi/lo remain 0xFFFF_FFFE/0x0000_0001; start+flush same cycle -> stays IDLE.
//  5. start re-asserted at T+5 with a=9,b=9 during a=2,b=3 op -> ignored, result lo=6, hi=0.
//  6. resetn low at T+20 mid-operation -> busy/done/hi/lo=0 immediately, no done after release;
//     random signed/unsigned regression (10k ops) vs 64-bit reference model.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: default operand width,
// iterative-engine state encoding and MDU operation codes.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate: result = en ? -value : value.
// Used for operand magnitudes and for the final sign fix-up of signed results.
module mdu_abs #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = en ? -value : value;

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (MULT/MULTU): one multiplier bit per cycle through a single
// WIDTH+1-bit adder; fixed latency of WIDTH+1 cycles from accepted start to done.
import mdu_pkg::*;

module mul_iter #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int          CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  mdu_state_e         state_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic               neg_q;
  logic [2*WIDTH:0]   acc_q;
  logic [CW-1:0]      counter_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     upper_d;
  logic [2*WIDTH:0]   acc_d;
  logic [2*WIDTH-1:0] product;
  logic               accept;

  // The most-negative operand negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
  mdu_abs #(.W(WIDTH)) u_abs_a (
    .en     (signed_op & a[WIDTH-1]),
    .value  (a),
    .result (abs_a)
  );

  mdu_abs #(.W(WIDTH)) u_abs_b (
    .en     (signed_op & b[WIDTH-1]),
    .value  (b),
    .result (abs_b)
  );

  // Sign fix works on the post-step accumulator so hi/lo are ready in the done cycle itself.
  mdu_abs #(.W(2*WIDTH)) u_sign_fix (
    .en     (neg_q),
    .value  (acc_d[2*WIDTH-1:0]),
    .result (product)
  );

  assign accept = (state_q == ST_IDLE) && start && !flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    upper_d = acc_q[2*WIDTH:WIDTH];
    if (acc_q[0]) begin
      upper_d = acc_q[2*WIDTH:WIDTH] + {1'b0, mag_a_q};
    end
    acc_d = {upper_d, acc_q[WIDTH-1:0]} >> 1;
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      mag_a_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      counter_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            mag_a_q   <= abs_a;
            neg_q     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q     <= {{(WIDTH+1){1'b0}}, abs_b};
            counter_q <= ITERS;
            busy_q    <= 1'b1;
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q     <= acc_d;
          counter_q <= counter_q - CW'(1);
          if (counter_q == CW'(1)) begin
            hi_q    <= product[2*WIDTH-1:WIDTH];
            lo_q    <= product[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
